permute_sched: RTL
==================

// Module: permute_sched
// PURPOSE
//  Sequencer for the 2*P-lane bank scatter network. For each NTT stage it steps
//  through the coefficient groups and emits one registered sel_in_bus beat per group.
//  Every beat is a bijection of lanes onto banks, so the network never collides.
//  Sits between the NTT stage controller (start/done) and the scatter network (sel_bus).
// PARAMETERS
//  N       2*`P   lanes/banks; power of two, >=2
//  SELW    `MAP   select width; 2**SELW == N
//  GROUPS  4      beats (groups) per stage, >=1
//  STAGES  3      stages per run, >=1
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        asynchronous, active-high reset
//  start      in   1        run request; sampled only in IDLE
//  out_ready  in   1        downstream accepts the current beat
//  busy       out  1        high from accepted start until done
//  out_valid  out  1        sel_bus/stage/grp are valid
//  sel_bus    out  N*SELW   lane j select in bits [j*SELW +: SELW]
//  stage      out  clog2(STAGES)  stage index of the beat (width >=1)
//  grp        out  clog2(GROUPS)  group index of the beat (width >=1)
//  last       out  1        beat is stage STAGES-1, group GROUPS-1
//  done       out  1        one-cycle pulse after the last beat handshake
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs 0: busy, out_valid, sel_bus, stage, grp, last, done.
//    Reset mid-run drops the run immediately; no done pulse is produced.
//  - FSM states: IDLE -> RUN -> DONE -> IDLE.
//    IDLE: start=1 loads stage=0, grp=0 and goes to RUN.
//          busy and out_valid both rise on the next edge (1-cycle latency).
//    RUN: out_valid=1. A handshake is out_valid&out_ready.
//         No handshake: all outputs hold stable.
//         Handshake: grp increments. At GROUPS-1, grp wraps to 0 and stage increments.
//         Handshake with last=1: go to DONE and clear out_valid on the same edge.
//    DONE: done=1 for exactly one cycle, busy=0, then IDLE.
//          start in DONE is ignored.
//  - start while busy is ignored. No queuing.
//  - Select rule, registered together with stage/grp:
//      mask    = 1 << (stage mod SELW)
//      sel[j]  = ((j ^ mask) + grp) mod N    (SELW-bit wrap)
//    XOR then add mod 2**SELW is bijective, so each bank is written exactly once.
//  - last = (stage==STAGES-1)&&(grp==GROUPS-1), combinational from the registered counters.
//  - Beats per run = STAGES*GROUPS. With out_ready tied high: done 1 cycle after the last beat.
//  - GROUPS=1: every beat increments stage. STAGES=GROUPS=1: a single beat, then DONE.
// CONFIGURATION
//  PERM_GATHER_EN defined:
//    Adds output gath_bus (N*SELW), registered alongside sel_bus.
//    gath[sel[j]] = j, i.e. the inverse permutation for the read-back gather network.
//    Its reset value is 0.
//  PERM_GATHER_EN undefined:
//    Port and logic are absent. All other behaviour is identical.
// TESTING (N=8, SELW=3, GROUPS=4, STAGES=3, out_ready=1 unless stated)
//  1 Reset, then idle 5 cycles -> all outputs 0; busy=0.
//  2 start pulse -> out_valid after 1 cycle.
//    Beat0 (s0,g0): sel = {1,0,3,2,5,4,7,6} for j=0..7.
//    Beat 6 (s1,g2): sel[0]=4, sel[7]=7.
//    12 beats total; last on beat 11 only; done 1 cycle later.
//  3 out_ready=0 for 3 cycles during beat 5 -> sel_bus/stage/grp frozen.
//    Sequence resumes at beat 5 with nothing skipped or duplicated.
//  4 start held high for a whole run -> start ignored while busy and in DONE.
//    Next run starts only after IDLE is re-entered.
//  5 rst asserted mid-run (beat 7) -> all outputs 0 asynchronously; no done.
//    Fresh start restarts at s0,g0.
//  6 Every beat: sel values are distinct (bijection check).
//    With PERM_GATHER_EN, check gath[sel[j]]==j for all j.
//    Beat0 gath = {1,0,3,2,5,4,7,6}.

Source files
------------

// File: rtl/permute_sched.sv
// Lane-to-bank select sequencer for the scatter network: one bijective select beat per group/stage.
// Optional PERM_GATHER_EN adds gath_bus carrying the inverse permutation.
module permute_sched #(
  parameter int unsigned N      = 8,
  parameter int unsigned SELW   = 3,
  parameter int unsigned GROUPS = 4,
  parameter int unsigned STAGES = 3,
  localparam int unsigned BUSW  = N * SELW,
  localparam int unsigned STW   = (STAGES > 1) ? $clog2(STAGES) : 1,
  localparam int unsigned GRW   = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            out_ready,
  output logic            busy,
  output logic            out_valid,
  output logic [BUSW-1:0] sel_bus,
  output logic [STW-1:0]  stage,
  output logic [GRW-1:0]  grp,
  output logic            last,
  output logic            done
`ifdef PERM_GATHER_EN
  ,
  output logic [BUSW-1:0] gath_bus
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;
  logic [STW-1:0]  stage_q, stage_d;
  logic [GRW-1:0]  grp_q, grp_d;
  logic [BUSW-1:0] sel_q, sel_d;
  logic            hs;
  logic            grp_wrap;
  logic            at_last;
  logic            load;

  // sel[j] = ((j ^ (1 << (stage mod SELW))) + grp) mod 2**SELW
  function automatic logic [BUSW-1:0] calc_sel(input logic [STW-1:0] s,
                                                input logic [GRW-1:0] g);
    logic [BUSW-1:0] v;
    logic [SELW-1:0] mask;
    int unsigned     sh;
    v    = '0;
    sh   = 32'(s) % SELW;
    mask = SELW'(1) << sh;
    for (int j = 0; j < int'(N); j++) begin
      v[j*SELW +: SELW] = (SELW'(j) ^ mask) + SELW'(g);
    end
    return v;
  endfunction

  assign hs       = valid_q & out_ready;
  assign grp_wrap = (grp_q == GRW'(GROUPS - 1));
  assign at_last  = (stage_q == STW'(STAGES - 1)) && grp_wrap;

  // Next-state and counter advance
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    stage_d = stage_q;
    grp_d   = grp_q;
    load    = 1'b0;
    sel_d   = sel_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          busy_d  = 1'b1;
          valid_d = 1'b1;
          stage_d = '0;
          grp_d   = '0;
          load    = 1'b1;
        end
      end
      S_RUN: begin
        if (hs) begin
          if (at_last) begin
            state_d = S_DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (grp_wrap) begin
            grp_d   = '0;
            stage_d = stage_q + STW'(1);
            load    = 1'b1;
          end else begin
            grp_d = grp_q + GRW'(1);
            load  = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Selects only change with the counters so idle outputs stay put
    if (load) begin
      sel_d = calc_sel(stage_d, grp_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      stage_q <= '0;
      grp_q   <= '0;
      sel_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      stage_q <= stage_d;
      grp_q   <= grp_d;
      sel_q   <= sel_d;
    end
  end

`ifdef PERM_GATHER_EN
  logic [BUSW-1:0] gath_q, gath_d;

  // Inverse permutation: gath[sel[j]] = j
  always_comb begin
    int idx;
    gath_d = gath_q;
    if (load) begin
      gath_d = '0;
      for (int j = 0; j < int'(N); j++) begin
        idx = int'(sel_d[j*SELW +: SELW]);
        gath_d[idx*SELW +: SELW] = SELW'(j);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gath_q <= '0;
    end else begin
      gath_q <= gath_d;
    end
  end

  assign gath_bus = gath_q;
`endif

  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign done      = done_q;
  assign stage     = stage_q;
  assign grp       = grp_q;
  assign sel_bus   = sel_q;
  // Gated by valid so the idle/reset value is 0 for any STAGES/GROUPS
  assign last      = valid_q & at_last;

endmodule
